// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Run / halt / single-step controller for the 5-stage pipeline core.
// Gates instruction fetch and pipeline advance from debug commands, drains
// in-flight instructions before halting, halts on a PC breakpoint, and keeps
// a saturating count of pipeline-advance cycles for bring-up.
//
// Optional feature: define RUN_CTRL_FLUSH_EN to turn command op 00 into FLUSH
// (one-cycle pipeline clear, accepted in HALTED only). Without the macro op 00
// is a NOP in every state and flush is tied low.

module pipeline_run_ctrl #(
    parameter int PC_W      = 8,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc_if,
    output logic             fetch_en,
    output logic             pipe_en,
    output logic             flush,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

    // Drain counter runs 0 .. DRAIN_CYC-1 while in DRAIN.
    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST =
        (DRAIN_CYC > 0) ? DCNT_W'(DRAIN_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_STEP   = 2'b11
    } state_t;

    // With no drain depth the pipeline stops straight into HALTED.
    localparam state_t STOP_STATE = (DRAIN_CYC == 0) ? ST_HALTED : ST_DRAIN;

    state_t             state_q,     state_d;
    logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic               resume_q,    resume_d;
    logic               bp_hit_q,    bp_hit_d;
    logic [CNT_W-1:0]   cyc_cnt_q,   cyc_cnt_d;
    logic               flush_pend;

    logic               bp_match;
    logic               bp_stop;
    logic               cmd_accept;

`ifdef RUN_CTRL_FLUSH_EN
    logic               flush_q,     flush_d;
    assign flush_pend = flush_q;
`else
    assign flush_pend = 1'b0;
`endif

    assign flush   = flush_pend;
    assign bp_hit  = bp_hit_q;
    assign cyc_cnt = cyc_cnt_q;

    // A breakpoint only stops a running pipeline, and never on the first RUN
    // cycle after HALTED so execution can resume from the breakpoint PC.
    assign bp_match   = bp_en && (pc_if == bp_addr);
    assign bp_stop    = (state_q == ST_RUN) && bp_match && !resume_q;
    assign cmd_accept = cmd_valid && cmd_ready;

    // Moore outputs from the state, with the breakpoint suppressing fetch.
    always_comb begin
        fetch_en  = 1'b0;
        pipe_en   = 1'b0;
        cmd_ready = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_HALTED: begin
                halted    = 1'b1;
                cmd_ready = !flush_pend;
            end
            ST_RUN: begin
                pipe_en   = 1'b1;
                fetch_en  = !bp_stop;
                cmd_ready = 1'b1;
            end
            ST_DRAIN: begin
                pipe_en   = 1'b1;
            end
            ST_STEP: begin
                pipe_en   = 1'b1;
                fetch_en  = 1'b1;
            end
            default: begin
                halted    = 1'b1;
            end
        endcase
    end

    // Next-state logic: command handling, breakpoint stop and drain timing.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        resume_d    = 1'b0;
        bp_hit_d    = bp_hit_q;
`ifdef RUN_CTRL_FLUSH_EN
        flush_d     = 1'b0;
`endif
        case (state_q)
            ST_HALTED: begin
                if (cmd_accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            resume_d = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            bp_hit_d = 1'b0;
                        end
                        OP_NOP: begin
`ifdef RUN_CTRL_FLUSH_EN
                            flush_d  = 1'b1;
`endif
                        end
                        default: begin
                            state_d  = ST_HALTED;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (bp_stop) begin
                    state_d     = STOP_STATE;
                    drain_cnt_d = '0;
                    bp_hit_d    = 1'b1;
                end else if (cmd_accept && (cmd_op == OP_HALT)) begin
                    state_d     = STOP_STATE;
                    drain_cnt_d = '0;
                end
            end
            ST_STEP: begin
                state_d     = STOP_STATE;
                drain_cnt_d = '0;
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_HALTED;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Advance-cycle counter saturates at all-ones instead of wrapping.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (pipe_en && (cyc_cnt_q != {CNT_W{1'b1}})) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALTED;
            drain_cnt_q <= '0;
            resume_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            resume_q    <= resume_d;
            bp_hit_q    <= bp_hit_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

`ifdef RUN_CTRL_FLUSH_EN
    // One-cycle flush pulse requested from HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl: a main instance (DRAIN_CYC=4, CNT_W=16)
// and a small one (DRAIN_CYC=0, CNT_W=4) share stimulus. A behavioural model
// predicts each cycle's outputs into a scoreboard queue that a negedge
// monitor drains; directed scenarios add spot checks on top.

module tb_pipeline_run_ctrl;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

`ifdef RUN_CTRL_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_STEP  = 3;

    typedef struct {
        int mode;
        int drainLeft;
        bit guard;
        bit bpHit;
        int cnt;
        bit flushPend;
    } mdl_t;

    typedef struct {
        bit       valid;
        bit [1:0] op;
        bit       bpEn;
        bit [7:0] bpAddr;
        bit [7:0] pc;
    } in_t;

    typedef struct packed {
        logic        fetch;
        logic        pipe;
        logic        flush;
        logic        halted;
        logic        bpHit;
        logic        ready;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc_if;

    logic        cmd_ready, fetch_en, pipe_en, flush, halted, bp_hit;
    logic [15:0] cyc_cnt;
    logic        cmd_ready_s, fetch_en_s, pipe_en_s, flush_s, halted_s, bp_hit_s;
    logic [3:0]  cyc_cnt_s;

    int   nCompared;
    int   nMismatched;
    sb_t  sbQ[$];
    mdl_t mA, mB;
    in_t  lastIn;
    bit   lastFetch;
    bit [7:0] pcReg;
    bit       bpEnReg;
    bit [7:0] bpAddrReg;

    pipeline_run_ctrl #(.PC_W(8), .CNT_W(16), .DRAIN_CYC(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .bp_en(bp_en), .bp_addr(bp_addr), .pc_if(pc_if),
        .fetch_en(fetch_en), .pipe_en(pipe_en), .flush(flush), .halted(halted),
        .bp_hit(bp_hit), .cyc_cnt(cyc_cnt)
    );

    pipeline_run_ctrl #(.PC_W(8), .CNT_W(4), .DRAIN_CYC(0)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_op(cmd_op), .bp_en(bp_en), .bp_addr(bp_addr), .pc_if(pc_if),
        .fetch_en(fetch_en_s), .pipe_en(pipe_en_s), .flush(flush_s), .halted(halted_s),
        .bp_hit(bp_hit_s), .cyc_cnt(cyc_cnt_s)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t modelReset();
        mdl_t m;
        m.mode = M_HALT;
        m.drainLeft = 0;
        m.guard = 1'b0;
        m.bpHit = 1'b0;
        m.cnt = 0;
        m.flushPend = 1'b0;
        return m;
    endfunction

    // Outputs the controller should present for model state m and inputs i.
    function automatic out_t modelOut(mdl_t m, in_t i);
        out_t o;
        bit   match;
        match = i.bpEn && (i.pc == i.bpAddr);
        o = '0;
        o.halted = (m.mode == M_HALT);
        o.pipe   = (m.mode != M_HALT);
        o.fetch  = (m.mode == M_STEP) || ((m.mode == M_RUN) && !(match && !m.guard));
        o.ready  = ((m.mode == M_HALT) && !m.flushPend) || (m.mode == M_RUN);
        o.flush  = m.flushPend;
        o.bpHit  = m.bpHit;
        o.cnt    = 16'(m.cnt);
        return o;
    endfunction

    // Model state after one clock edge with inputs i.
    function automatic mdl_t modelNext(mdl_t m, in_t i, int drainCyc, int cntMax);
        mdl_t n;
        out_t o;
        bit   accept;
        bit   bpStop;
        bit   stop;
        n = m;
        o = modelOut(m, i);
        accept = i.valid && o.ready;
        bpStop = (m.mode == M_RUN) && i.bpEn && (i.pc == i.bpAddr) && !m.guard;
        stop = 1'b0;
        if (o.pipe && (n.cnt < cntMax)) n.cnt = n.cnt + 1;
        n.guard = 1'b0;
        n.flushPend = 1'b0;
        if (m.mode == M_HALT) begin
            if (accept && (i.op == OP_RUN)) begin
                n.mode = M_RUN; n.guard = 1'b1; n.bpHit = 1'b0;
            end else if (accept && (i.op == OP_STEP)) begin
                n.mode = M_STEP; n.bpHit = 1'b0;
            end else if (accept && (i.op == OP_NOP) && FLUSH_ON) begin
                n.flushPend = 1'b1;
            end
        end else if (m.mode == M_RUN) begin
            if (bpStop) n.bpHit = 1'b1;
            stop = bpStop || (accept && (i.op == OP_HALT));
        end else if (m.mode == M_STEP) begin
            stop = 1'b1;
        end else begin
            n.drainLeft = n.drainLeft - 1;
            if (n.drainLeft == 0) n.mode = M_HALT;
        end
        if (stop) begin
            n.mode = (drainCyc == 0) ? M_HALT : M_DRAIN;
            n.drainLeft = drainCyc;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the predicted outputs for it.
    task automatic applyStimulus(input bit v, input bit [1:0] op);
        out_t expA, expB;
        @(posedge clk);
        if (rst_n) begin
            mA = modelNext(mA, lastIn, 4, 65535);
            mB = modelNext(mB, lastIn, 0, 15);
            if (lastFetch) pcReg = pcReg + 8'd1;
        end
        #1;
        cmd_valid = v;
        cmd_op    = op;
        bp_en     = bpEnReg;
        bp_addr   = bpAddrReg;
        pc_if     = pcReg;
        lastIn.valid  = v;
        lastIn.op     = op;
        lastIn.bpEn   = bpEnReg;
        lastIn.bpAddr = bpAddrReg;
        lastIn.pc     = pcReg;
        expA = modelOut(mA, lastIn);
        expB = modelOut(mB, lastIn);
        lastFetch = expA.fetch;
        sbQ.push_back('{a: expA, b: expB});
        @(negedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, checked before the next clock edge.
    task automatic resetPulse();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pipe_en", 32'(pipe_en), 32'd0);
        checkOutput("rst_fetch_en", 32'(fetch_en), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd1);
        checkOutput("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
        checkOutput("rst_bp_hit", 32'(bp_hit), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        mA = modelReset();
        mB = modelReset();
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
        lastIn.valid = 1'b0;
        lastIn.op = OP_NOP;
        lastFetch = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented output set against the scoreboard.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            sb_t  e;
            out_t actA, actB;
            e = sbQ.pop_front();
            actA = {fetch_en, pipe_en, flush, halted, bp_hit, cmd_ready, cyc_cnt};
            actB = {fetch_en_s, pipe_en_s, flush_s, halted_s, bp_hit_s, cmd_ready_s, 12'd0, cyc_cnt_s};
            nCompared += 2;
            if (actA !== e.a) begin
                nMismatched++;
                $display("[TB] FAIL sb_main: got %h, expected %h (fetch,pipe,flush,halted,bp_hit,ready,cnt) at %0t",
                         actA, e.a, $time);
            end
            if (actB !== e.b) begin
                nMismatched++;
                $display("[TB] FAIL sb_small: got %h, expected %h (fetch,pipe,flush,halted,bp_hit,ready,cnt) at %0t",
                         actB, e.b, $time);
            end
        end
    end

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
        bpEnReg = 1'b0;
        bpAddrReg = 8'h00;
        pcReg = 8'h00;
        bp_en = 1'b0;
        bp_addr = 8'h00;
        pc_if = 8'h00;
        mA = modelReset();
        mB = modelReset();
        lastIn = '{valid: 1'b0, op: OP_NOP, bpEn: 1'b0, bpAddr: 8'h00, pc: 8'h00};
        lastFetch = 1'b0;
        #12;
        resetPulse();

        // RUN accepted at edge 0, HALT at edge 10.
        $display("[TB] run/halt sequence");
        applyStimulus(1'b1, OP_RUN);
        for (int k = 0; k < 9; k++) applyStimulus(1'b0, OP_NOP);
        checkOutput("run_fetch_c8", 32'(fetch_en), 32'd1);
        applyStimulus(1'b1, OP_HALT);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, OP_NOP);
            checkOutput("drain_fetch", 32'(fetch_en), 32'd0);
            checkOutput("drain_pipe", 32'(pipe_en), 32'd1);
        end
        applyStimulus(1'b0, OP_NOP);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_pipe", 32'(pipe_en), 32'd0);
        checkOutput("halt_cyc_cnt", 32'(cyc_cnt), 32'd14);
        checkOutput("halt_bp_hit", 32'(bp_hit), 32'd0);

        // Single step from HALTED.
        $display("[TB] single step");
        applyStimulus(1'b1, OP_STEP);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, OP_NOP);
            checkOutput("step_pipe", 32'(pipe_en), 32'd1);
            checkOutput("step_ready", 32'(cmd_ready), 32'd0);
            checkOutput("step_fetch", 32'(fetch_en), (k == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, OP_NOP);
        checkOutput("step_halted", 32'(halted), 32'd1);
        checkOutput("step_cyc_cnt", 32'(cyc_cnt), 32'd19);

        // Reset while running, then idle in HALTED.
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, OP_RUN);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, OP_NOP);
        resetPulse();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, OP_NOP);
        checkOutput("post_rst_halted", 32'(halted), 32'd1);

        // Breakpoint at 0x20 with the PC walking up from 0x1C.
        $display("[TB] breakpoint");
        bpEnReg = 1'b1;
        bpAddrReg = 8'h20;
        pcReg = 8'h1C;
        applyStimulus(1'b1, OP_RUN);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, OP_NOP);
            checkOutput("bp_pre_fetch", 32'(fetch_en), 32'd1);
        end
        applyStimulus(1'b0, OP_NOP);
        checkOutput("bp_pc", 32'(pc_if), 32'h20);
        checkOutput("bp_fetch_blocked", 32'(fetch_en), 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, OP_NOP);
        applyStimulus(1'b1, OP_RUN);
        checkOutput("bp_halted", 32'(halted), 32'd1);
        checkOutput("bp_hit_set", 32'(bp_hit), 32'd1);
        applyStimulus(1'b0, OP_NOP);
        checkOutput("bp_resume_fetch", 32'(fetch_en), 32'd1);
        checkOutput("bp_hit_cleared", 32'(bp_hit), 32'd0);
        applyStimulus(1'b1, OP_HALT);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, OP_NOP);
        bpEnReg = 1'b0;

        // Flush / NOP command in HALTED and in RUN.
        $display("[TB] op 00 handling");
        applyStimulus(1'b1, OP_NOP);
        applyStimulus(1'b0, OP_NOP);
        checkOutput("flush_halted", 32'(flush), 32'(FLUSH_ON));
        checkOutput("flush_pipe", 32'(pipe_en), 32'd0);
        checkOutput("flush_ready", 32'(cmd_ready), 32'(!FLUSH_ON));
        applyStimulus(1'b0, OP_NOP);
        checkOutput("flush_one_cycle", 32'(flush), 32'd0);
        applyStimulus(1'b1, OP_RUN);
        applyStimulus(1'b1, OP_NOP);
        applyStimulus(1'b0, OP_NOP);
        checkOutput("flush_in_run", 32'(flush), 32'd0);

        // Saturation: hold RUN for 20 cycles.
        $display("[TB] counter saturation");
        resetPulse();
        applyStimulus(1'b1, OP_RUN);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, OP_RUN);
        checkOutput("sat_small_cnt", 32'(cyc_cnt_s), 32'd15);
        checkOutput("sat_main_cnt", 32'(cyc_cnt), 32'd19);
        applyStimulus(1'b1, OP_HALT);

        // Randomised traffic with one reset in the middle.
        $display("[TB] random traffic");
        for (int c = 0; c < 1200; c++) begin
            bit       v;
            bit [1:0] op;
            if (c == 600) resetPulse();
            if ($urandom_range(0, 15) == 0) pcReg = 8'($urandom);
            if ($urandom_range(0, 30) == 0) bpEnReg = ~bpEnReg;
            if ($urandom_range(0, 7) == 0) bpAddrReg = pcReg + 8'($urandom_range(0, 6));
            v  = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            applyStimulus(v, op);
        end

        @(negedge clk);
        #1;
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
